// File: rtl/grf_pkg.sv
// grf_pkg: shared definitions for the grf_sb register file with scoreboard.
//   - Default geometry (data width, address width, pending-counter width)
//   - Derived DEPTH and CNT_MAX
//   - cnt_next(): next-state rule for one pending-write counter
// Counters up to 8 bits wide are supported by cnt_next().
package grf_pkg;

  localparam int GRF_DATA_W  = 32;
  localparam int GRF_ADDR_W  = 5;
  localparam int GRF_CNT_W   = 2;
  localparam int GRF_DEPTH   = 2 ** GRF_ADDR_W;
  localparam int GRF_CNT_MAX = (2 ** GRF_CNT_W) - 1;

  typedef struct packed {
    logic [7:0] cnt_n;
    logic       ovf_set;
  } cnt_upd_t;

  // A reservation and a writeback landing on the same register cancel out.
  // A reservation at the ceiling is dropped and flagged; a writeback at zero
  // is an untracked write and leaves the count alone.
  function automatic cnt_upd_t cnt_next(input logic       rsv,
                                        input logic       wr,
                                        input logic [7:0] cnt,
                                        input logic [7:0] cnt_max);
    cnt_upd_t u;
    u.cnt_n   = cnt;
    u.ovf_set = 1'b0;
    if (rsv && !wr) begin
      if (cnt == cnt_max) u.ovf_set = 1'b1;
      else                u.cnt_n   = cnt + 8'd1;
    end else if (wr && !rsv) begin
      if (cnt != 8'd0) u.cnt_n = cnt - 8'd1;
    end
    return u;
  endfunction

endpackage

// File: rtl/grf_sb_cnt.sv
// grf_sb_cnt: one saturating pending-write counter for a single register.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   i_flush      clear the count, discarding this cycle's rsv/wr effects
//   i_rsv_hit    a reservation targets this register
//   i_wr_hit     a writeback targets this register
//   o_cnt        current pending-write count
//   o_ovf_set    a reservation is being dropped at the ceiling this cycle
module grf_sb_cnt
  import grf_pkg::*;
#(
  parameter int CNT_W = GRF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_rsv_hit,
  input  logic             i_wr_hit,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_ovf_set
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt;
  cnt_upd_t         w_upd;

  assign w_upd = cnt_next(i_rsv_hit, i_wr_hit, 8'(r_cnt), 8'(CNT_MAX));

  always_ff @(posedge clk) begin
    if (reset)        r_cnt <= '0;
    else if (i_flush) r_cnt <= '0;
    else              r_cnt <= w_upd.cnt_n[CNT_W-1:0];
  end

  // A flushed cycle discards the reservation, so it cannot overflow either.
  assign o_ovf_set = w_upd.ovf_set && !i_flush && !reset;
  assign o_cnt     = r_cnt;

endmodule

// File: rtl/grf_sb.sv
// grf_sb: general register file with per-register pending-write scoreboard.
// Register 0 reads as zero and is never busy; writes/reservations to it are
// ignored. Reads are combinational.
// Optional feature macro: GRF_BYPASS_EN -- write-through of the concurrent
// writeback onto the read ports, with busy taken from the post-writeback count.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   rd_addr      NUM_RD packed read addresses
//   rd_data      NUM_RD packed read data
//   rd_busy      per read port: addressed register has a pending write
//   rsv_en/addr  reserve a destination at issue
//   wr_en/addr/data  writeback
//   flush        clear all pending counters
//   ovf          sticky: a reservation was dropped at the counter ceiling
module grf_sb
  import grf_pkg::*;
#(
  parameter int DATA_W = GRF_DATA_W,
  parameter int ADDR_W = GRF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int CNT_W  = GRF_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     flush,
  output logic                     ovf
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [CNT_W-1:0]  w_cnt  [DEPTH];
  logic [DEPTH-1:0]  w_ovf_set;
  logic              r_ovf;

  // Storage: entry 0 is cleared by reset and never written, so it stays zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  // Register 0 has no counter; it is permanently not busy.
  assign w_cnt[0]     = '0;
  assign w_ovf_set[0] = 1'b0;

  for (genvar r = 1; r < DEPTH; r++) begin : g_cnt
    grf_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .i_flush   (flush),
      .i_rsv_hit (rsv_en && (rsv_addr == ADDR_W'(r))),
      .i_wr_hit  (wr_en && (wr_addr == ADDR_W'(r))),
      .o_cnt     (w_cnt[r]),
      .o_ovf_set (w_ovf_set[r])
    );
  end

  always_ff @(posedge clk) begin
    if (reset)           r_ovf <= 1'b0;
    else if (|w_ovf_set) r_ovf <= 1'b1;
  end

  assign ovf = r_ovf;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    assign w_ra = rd_addr[k*ADDR_W +: ADDR_W];
`ifdef GRF_BYPASS_EN
    logic w_wr_hit;
    logic w_rsv_hit;
    assign w_wr_hit  = wr_en && (wr_addr == w_ra) && (w_ra != '0);
    assign w_rsv_hit = rsv_en && (rsv_addr == w_ra);
    assign rd_data[k*DATA_W +: DATA_W] = w_wr_hit ? wr_data : r_regs[w_ra];
    // Busy reflects the count after this cycle's writeback retires one entry;
    // a same-cycle reservation cancels that decrement.
    assign rd_busy[k] = (w_wr_hit && !w_rsv_hit && (w_cnt[w_ra] != '0))
                        ? (w_cnt[w_ra] != CNT_W'(1))
                        : (w_cnt[w_ra] != '0);
`else
    assign rd_data[k*DATA_W +: DATA_W] = r_regs[w_ra];
    assign rd_busy[k]                  = (w_cnt[w_ra] != '0);
`endif
  end

endmodule
